// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and default line parameters for the UART transmitter
package serial_pkg;

    localparam int CLK_FREQ_DEFAULT = 100_000_000;
    localparam int BAUD_DEFAULT     = 115_200;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

endpackage

// File: rtl/serial_baud_gen.sv
// serial_baud_gen: bit-period counter emitting a one-cycle tick on the last cycle of each bit
module serial_baud_gen #(
    parameter int CLK_MUL = 868,
    parameter int W       = $clog2(CLK_MUL)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [W-1:0] cnt;

    assign tick = en && cnt == W'(CLK_MUL - 1);

    // count 0..CLK_MUL-1 while a frame runs, parked at 0 otherwise
    always_ff @(posedge clk) begin
        if (rst || !en)
            cnt <= '0;
        else
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/serial.sv
// serial: 8N1 UART transmitter with registered tx/busy and zero-latency frame start
module serial
    import serial_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
    parameter int BAUD     = BAUD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       txe,
    output logic       tx,
    output logic       busy
);

    localparam int CLK_MUL       = CLK_FREQ / BAUD;
    localparam int CLK_MUL_WIDTH = $clog2(CLK_MUL);

    if (CLK_MUL < 2) begin : g_bad_clk_mul
        $error("serial: CLK_FREQ / BAUD must be at least 2");
    end

    state_t     state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] idx, idx_n;
    logic       tx_n, busy_n;
    logic       tick;

    serial_baud_gen #(
        .CLK_MUL (CLK_MUL),
        .W       (CLK_MUL_WIDTH)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .tick (tick)
    );

    // next-state and next-output logic; tx/busy are computed one edge ahead so they leave as flops
    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n   = idx;
        tx_n    = tx;
        busy_n  = busy;
        case (state)
            IDLE: if (txe) begin
                state_n = START;
                shift_n = data;
                idx_n   = '0;
                tx_n    = 1'b0;
                busy_n  = 1'b1;
            end
            START: if (tick) begin
                state_n = DATA;
                tx_n    = shift[0];
                shift_n = {1'b0, shift[7:1]};
            end
            DATA: if (tick) begin
                state_n = idx == 3'd7 ? STOP : DATA;
                tx_n    = idx == 3'd7 ? 1'b1 : shift[0];
                shift_n = {1'b0, shift[7:1]};
                idx_n   = idx + 3'd1;
            end
            STOP: if (tick) begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    // state and output registers; reset aborts any frame and idles the line
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shift <= '0;
            idx   <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            shift <= shift_n;
            idx   <= idx_n;
            tx    <= tx_n;
            busy  <= busy_n;
        end
    end

endmodule

// File: tb/tb_serial.sv
// tb_serial: randomized and directed checks of serial against a frame-level line model
module tb_serial;

    localparam int CLK_FREQ      = 100_000_000;
    localparam int BAUD          = 115_200;
    localparam int CLK_MUL       = CLK_FREQ / BAUD;
    localparam int CLK_MUL_WIDTH = $clog2(CLK_MUL);
    localparam int FRAME         = 10 * CLK_MUL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = '0;
    logic       txe = 1'b0;
    logic       tx, busy;

    int errors = 0;
    int checks = 0;
    logic mon = 1'b0;

    logic       m_busy = 1'b0;
    int         m_t = 0;
    logic [9:0] m_frame = '1;
    logic       exp_tx;

    serial dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .txe  (txe),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // frame model: a 10-bit frame vector indexed by elapsed cycles / bit period
    always @(posedge clk) begin
        if (rst)
            m_busy <= 1'b0;
        else if (!m_busy && txe) begin
            m_busy  <= 1'b1;
            m_frame <= {1'b1, data, 1'b0};
            m_t     <= 0;
        end else if (m_busy) begin
            if (m_t == FRAME - 1)
                m_busy <= 1'b0;
            else
                m_t <= m_t + 1;
        end
    end

    assign exp_tx = m_busy ? m_frame[m_t / CLK_MUL] : 1'b1;

    // compare the line against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (mon) begin
            chk("tx_model", tx, exp_tx);
            chk("busy_model", busy, m_busy);
        end
    end

    task automatic send(input logic [7:0] d, input logic [7:0] d_after, input int pulse);
        int c;
        int hi;
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        data = d;
        txe = 1'b1;
        @(negedge clk);
        hi = 0;
        c = 0;
        while (busy && c < 11 * CLK_MUL) begin
            if (c == 0) data = d_after;
            if (c == pulse - 1) txe = 1'b0;
            if (c % CLK_MUL == CLK_MUL / 2) chk("bit", tx, f[c / CLK_MUL]);
            hi++;
            c++;
            @(negedge clk);
        end
        txe = 1'b0;
        chk("busy_cycles", hi, FRAME);
        chk("after_stop_tx", tx, 1);
    endtask

    task automatic idle_for(input int n, input string tag);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic wait_busy(input logic val, input int limit, input string tag);
        int n;
        n = 0;
        while (busy !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, busy, val);
    endtask

    initial begin
        int gap;
        $display("CLK_FREQ=%0d BAUD=%0d CLK_MUL=%0d CLK_MUL_WIDTH=%0d", CLK_FREQ, BAUD, CLK_MUL, CLK_MUL_WIDTH);
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        mon = 1'b1;

        idle_for(1000, "idle_10us");
        send(8'h59, 8'h59, 2);
        idle_for(2000, "single_frame");

        data = 8'hA5;
        txe = 1'b1;
        wait_busy(1'b1, 5, "b2b_start");
        wait_busy(1'b0, 11 * CLK_MUL, "b2b_end1");
        chk("b2b_gap_tx", tx, 1);
        gap = 0;
        while (!busy && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        chk("b2b_gap", gap, 1);
        txe = 1'b0;
        wait_busy(1'b0, 11 * CLK_MUL, "b2b_end2");
        idle_for(100, "b2b_stop");

        data = 8'h00;
        txe = 1'b1;
        @(negedge clk);
        txe = 1'b0;
        repeat (3 * CLK_MUL + 400) @(negedge clk);
        chk("abort_midframe_busy", busy, 1);
        chk("abort_midframe_tx", tx, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        rst = 1'b0;
        idle_for(2000, "abort_idle");

        send(8'h59, 8'hFF, 1);
        idle_for(50, "data_change_idle");

        rst = 1'b1;
        txe = 1'b1;
        data = 8'h3C;
        @(negedge clk);
        chk("rst_prio_tx", tx, 1);
        chk("rst_prio_busy", busy, 0);
        rst = 1'b0;
        txe = 1'b0;
        idle_for(5, "rst_prio_idle");

        repeat (2) begin
            repeat ($urandom_range(1, 50)) @(negedge clk);
            send(8'($urandom), 8'($urandom), $urandom_range(1, 3));
        end
        idle_for(20, "rand_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
